// File: rtl/fifo_axis_reader_if.sv
// fifo_axis_reader_if
// Bundles the FIFO read port and the AXI4-Stream port seen by fifo_axis_reader.
//   fifo_rd_en     : FIFO read strobe (reader -> FIFO)
//   fifo_empty     : FIFO empty flag (FIFO -> reader)
//   fifo_dout      : FIFO read data, valid the cycle after an accepted read
//   m_axis_tdata   : stream data (reader -> sink)
//   m_axis_tvalid  : stream valid (reader -> sink)
//   m_axis_tready  : stream ready (sink -> reader)
//   m_axis_tlast   : end-of-burst marker, present only when
//                    FIFO_AXIS_READER_TLAST_EN is defined
// master modport = the reader's view, slave modport = the environment's view.
interface fifo_axis_reader_if #(
  parameter int B = 160
);
  logic         fifo_rd_en;
  logic         fifo_empty;
  logic [B-1:0] fifo_dout;
  logic [B-1:0] m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
`ifdef FIFO_AXIS_READER_TLAST_EN
  logic         m_axis_tlast;

  modport master (
    output fifo_rd_en,
    input  fifo_empty,
    input  fifo_dout,
    output m_axis_tdata,
    output m_axis_tvalid,
    input  m_axis_tready,
    output m_axis_tlast
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_empty,
    output fifo_dout,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    output m_axis_tready,
    input  m_axis_tlast
  );
`else
  modport master (
    output fifo_rd_en,
    input  fifo_empty,
    input  fifo_dout,
    output m_axis_tdata,
    output m_axis_tvalid,
    input  m_axis_tready
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_empty,
    output fifo_dout,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    output m_axis_tready
  );
`endif
endinterface

// File: rtl/fifo_axis_reader.sv
// fifo_axis_reader
// Drains a 1-cycle-latency FIFO (rd_en/dout/empty) and presents the words as
// an AXI4-Stream master. A 2-entry head/tail buffer absorbs the read latency
// so a continuously ready sink gets one word per clock, and no word is lost
// or duplicated under any backpressure pattern.
//
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous reset, active high
//   en        : allow new FIFO reads; buffered / in-flight words still drain
//   burst_len : beats per burst (only with FIFO_AXIS_READER_TLAST_EN)
//   bus       : fifo_axis_reader_if.master (FIFO read port + AXIS master)
//   beat_cnt  : wrapping count of accepted beats (tvalid & tready)
//   idle      : buffer empty, no read in flight and en low
//
// Optional feature macro: FIFO_AXIS_READER_TLAST_EN adds burst_len and
// m_axis_tlast. Without it neither port nor any tlast logic exists.
module fifo_axis_reader #(
  parameter int B     = 160,
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
`ifdef FIFO_AXIS_READER_TLAST_EN
  input  logic [15:0]          burst_len,
`endif
  fifo_axis_reader_if.master   bus,
  output logic [CNT_W-1:0]     beat_cnt,
  output logic                 idle
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]       occ_reg, occ_next;
  logic             inflight_reg, inflight_next;
  logic             tvalid_reg, tvalid_next;
  logic [B-1:0]     head_reg, head_next;
  logic [B-1:0]     tail_reg, tail_next;
  logic [CNT_W-1:0] beat_cnt_reg, beat_cnt_next;

  logic             pop;
  logic             rd_en;
  logic [2:0]       pending;
  logic [1:0]       occ_after_pop;

  // ---------------------------------------------------------------------------
  // Read issue
  // ---------------------------------------------------------------------------
  // pending = words that will occupy the buffer after this edge if no new
  // read is issued. A read is only issued when it is guaranteed a slot, which
  // bounds the buffer to 2 entries and makes a stall stop reads after 2 words.
  // tvalid_reg always equals (occ_reg != 0), so pop implies occ_reg >= 1 and
  // the subtraction cannot underflow.
  always_comb begin
    pop     = tvalid_reg & bus.m_axis_tready;
    pending = {1'b0, occ_reg} + {2'b00, inflight_reg} - {2'b00, pop};
    rd_en   = en & ~bus.fifo_empty & (pending < 3'd2);
  end

  // ---------------------------------------------------------------------------
  // Buffer next state
  // ---------------------------------------------------------------------------
  always_comb begin
    head_next     = head_reg;
    tail_next     = tail_reg;
    occ_after_pop = occ_reg - {1'b0, pop};

    // Popping a full buffer promotes the tail word so head stays the oldest.
    if (pop && (occ_reg == 2'd2)) begin
      head_next = tail_reg;
    end

    // The word read last cycle lands in the first free slot after the pop.
    if (inflight_reg) begin
      if (occ_after_pop == 2'd0) begin
        head_next = bus.fifo_dout;
      end else begin
        tail_next = bus.fifo_dout;
      end
    end

    occ_next      = occ_after_pop + {1'b0, inflight_reg};
    tvalid_next   = (occ_next != 2'd0);
    inflight_next = rd_en;
    beat_cnt_next = beat_cnt_reg + CNT_W'(pop);
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // Reset drops everything, including the word whose read was issued in the
  // previous cycle (inflight is cleared, so it is never captured).
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_reg      <= 2'd0;
      inflight_reg <= 1'b0;
      tvalid_reg   <= 1'b0;
      head_reg     <= '0;
      tail_reg     <= '0;
      beat_cnt_reg <= '0;
    end else begin
      occ_reg      <= occ_next;
      inflight_reg <= inflight_next;
      tvalid_reg   <= tvalid_next;
      head_reg     <= head_next;
      tail_reg     <= tail_next;
      beat_cnt_reg <= beat_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional end-of-burst marker
  // ---------------------------------------------------------------------------
`ifdef FIFO_AXIS_READER_TLAST_EN
  logic [15:0] bcnt_reg, bcnt_next;
  logic [15:0] len_reg, len_next;
  logic [15:0] len_eff;
  logic        head_last;

  // At the first beat of a burst the live burst_len applies; it is latched on
  // that beat's pop and used for the rest of the burst. burst_len is expected
  // to be quasi-static between bursts, which keeps tlast stable under stall.
  always_comb begin
    len_eff   = (bcnt_reg == 16'd0) ? burst_len : len_reg;
    head_last = (len_eff <= 16'd1) ||
                (({1'b0, bcnt_reg} + 17'd1) >= {1'b0, len_eff});
    bcnt_next = bcnt_reg;
    len_next  = len_reg;
    if (pop) begin
      if (bcnt_reg == 16'd0) begin
        len_next = burst_len;
      end
      bcnt_next = head_last ? 16'd0 : (bcnt_reg + 16'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt_reg <= 16'd0;
      len_reg  <= 16'd0;
    end else begin
      bcnt_reg <= bcnt_next;
      len_reg  <= len_next;
    end
  end

  assign bus.m_axis_tlast = tvalid_reg & head_last;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.fifo_rd_en    = rd_en;
  assign bus.m_axis_tdata  = head_reg;
  assign bus.m_axis_tvalid = tvalid_reg;
  assign beat_cnt          = beat_cnt_reg;
  assign idle              = (occ_reg == 2'd0) & ~inflight_reg & ~en;

endmodule

// File: doc/fifo_axis_reader.md
Name: fifo_axis_reader

Overview:
- Read-side companion to fifo_behav (B-bit data, depth N). Drains the FIFO through its rd_en/dout/empty port and presents the words as an AXI4-Stream master.
- Sits between the signal-generator FIFOs and downstream AXIS consumers.
- Absorbs the FIFO's 1-cycle read latency with a 2-entry output buffer, so a continuously-ready sink receives one word per clock.
- No word is lost or duplicated under any backpressure pattern.

Parameters:
- B, 160, data width in bits; must match the source FIFO.
- CNT_W, 32, width of the delivered-beat counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  read enable; when 0, no new FIFO reads are issued. In-flight and buffered words still drain.
- fifo_empty  in  1  FIFO empty flag.
- fifo_dout  in  B  FIFO read data; valid the cycle after fifo_rd_en=1 was issued with fifo_empty=0.
- fifo_rd_en  out  1  FIFO read strobe.
- m_axis_tdata  out  B  stream data.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- beat_cnt  out  CNT_W  count of accepted beats (tvalid & tready).
- idle  out  1  high when buffer occupancy=0, no read in flight and en=0.

Behaviour:
- Reset (rst=1 at a rising edge): fifo_rd_en=0, m_axis_tvalid=0, m_axis_tdata=0, beat_cnt=0, occupancy=0, in-flight flag=0. idle follows its definition after reset.
- Reset mid-operation: buffered and in-flight words are discarded. A FIFO word read in the reset cycle is dropped and never presented.
- State:
  - 2-entry buffer, head slot and tail slot; occ in 0..2.
  - inflight flag = fifo_rd_en was asserted last cycle.
- pop = m_axis_tvalid & m_axis_tready.
- fifo_rd_en = en & ~fifo_empty & ((occ + inflight - pop) < 2).
  - Combinational from m_axis_tready and fifo_empty; permitted, since the FIFO samples rd_en on the edge.
  - Never asserted while fifo_empty=1. The FIFO's own underflow guard must not be relied upon.
- Capture: when inflight=1, fifo_dout is written into the buffer on that edge.
  - Target is the head slot if it is empty after this cycle's pop; otherwise the tail slot.
- Simultaneous pop and capture: tail shifts to head, and the new word lands in tail (or head if occ was 1). occ is unchanged.
- m_axis_tvalid = (occ > 0); m_axis_tdata = head slot. Both are registered outputs.
- AXIS rules:
  - tdata and tvalid hold stable while tvalid=1 and tready=0.
  - tvalid never deasserts without a pop.
- Latency: FIFO non-empty at cycle 0 with en=1 and occ=0 → fifo_rd_en in cycle 0, capture at edge ending cycle 1, tvalid=1 in cycle 2.
- Throughput: with tready held high and FIFO non-empty, fifo_rd_en=1 and a pop every cycle in steady state.
- Backpressure: with tready=0, at most 2 further words are read after the stall begins; fifo_rd_en then stays 0.
- Ordering: output order equals FIFO read order. Head is always the oldest word.
- beat_cnt increments by 1 per pop and wraps from 2^CNT_W-1 to 0.
- en deassert: reads stop the same cycle. The in-flight word is still captured, and the buffer continues to drain.

Optional Feature:
- Macro: FIFO_AXIS_READER_TLAST_EN.
- When defined:
  - Adds input burst_len (16 bits) and output m_axis_tlast (1 bit, reset 0).
  - An internal beat counter counts pops. m_axis_tlast=1 on the head word that is the burst_len-th beat of the current burst; the counter returns to 0 after that pop.
  - burst_len=0 or 1 → tlast on every beat.
  - burst_len is sampled at the first beat of each burst.
  - tlast obeys the same hold rules as tdata.
- When undefined: neither port exists and no tlast logic is generated.

Test Plan:
- Reset then preload the FIFO with 8 words 0x1..0x8; en=1, tready=1 → tvalid rises 2 cycles after the first fifo_rd_en; words 0x1..0x8 appear on 8 consecutive cycles; beat_cnt=8; idle=1 once en=0.
- 8 words queued, tready=0 → exactly 2 fifo_rd_en pulses, tvalid=1, tdata=0x1 held stable. Then tready=1 → 0x1..0x8 in order, no gaps after the first.
- Random tready (50%) with random FIFO writes, 10000 cycles against a scoreboard model → no loss, duplication or reorder; fifo_rd_en never high while fifo_empty=1.
- rst asserted for 1 cycle while occ=2 with a read in flight → next cycle tvalid=0, beat_cnt=0. The in-flight word is never output, and subsequent words stream correctly.
- CNT_W=4, 17 beats → beat_cnt reads 1 after wrap (15→0→1).
- FIFO_AXIS_READER_TLAST_EN defined, burst_len=4, 12 beats → tlast on beats 4, 8, 12. burst_len=1 → tlast on every beat; stall mid-burst keeps tlast held.
